// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and the legal range of the operand width parameter.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_subtractor_full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out when the
// minuend bit cannot cover the subtrahend bit plus the incoming borrow.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out of a single bit position
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor. A single full-subtractor cell is
// reused once per clock; the borrow is carried between bits in a flop.
// Operands are captured on start, the result is published with a
// one-cycle done pulse, and each difference bit is also streamed out.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ser_d,
  output logic             ser_vld
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Reject widths the counter and shift logic were not sized for
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : gWidthCheck
    $error("serial_subtractor: WIDTH out of range");
  end

  state_t           state_q;
  logic [WIDTH-1:0] aSr_q;
  logic [WIDTH-1:0] bSr_q;
  logic [WIDTH-1:0] diffSr_q;
  logic             brw_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             serD_q;
  logic             serVld_q;

  logic             cellD_d;
  logic             cellBout_d;
  logic [WIDTH-1:0] diffSr_d;

  full_subtractor_cell uCell (
    .a    (aSr_q[0]),
    .b    (bSr_q[0]),
    .bin  (brw_q),
    .d    (cellD_d),
    .bout (cellBout_d)
  );

  // Difference shift register after the current bit lands at the MSB end
  always_comb begin
    diffSr_d = {cellD_d, diffSr_q[WIDTH-1:1]};
  end

  // Control FSM, operand shifters, borrow flop and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      aSr_q    <= '0;
      bSr_q    <= '0;
      diffSr_q <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      serD_q   <= 1'b0;
      serVld_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          aSr_q    <= aSr_q >> 1;
          bSr_q    <= bSr_q >> 1;
          diffSr_q <= diffSr_d;
          brw_q    <= cellBout_d;
          serD_q   <= cellD_d;
          serVld_q <= 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            diff_q  <= diffSr_d;
            bout_q  <= cellBout_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          done_q   <= 1'b0;
          serD_q   <= 1'b0;
          serVld_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            aSr_q   <= a;
            bSr_q   <= b;
            brw_q   <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign diff    = diff_q;
  assign bout    = bout_q;
  assign ser_d   = serD_q;
  assign ser_vld = serVld_q;

endmodule
